// File: rtl/imem_loadable.sv
// ---------------------------------------------------------------------------
// imem_loadable
//   Word-organised instruction memory for the RV32I core. A registered fetch
//   port returns one instruction per requested cycle, with valid and fault
//   flags. A byte-serial load port fills the array at run time, for example
//   from a UART or debug loader.
//
//   Handshakes:
//     fetch: fetch_req high at edge N gives fetch_valid high for exactly one
//            cycle after edge N. fetch_instr and fetch_fault are meaningful
//            only while fetch_valid is high. There is no back-pressure, so
//            back-to-back requests give one result per cycle.
//     load : a byte is consumed on every edge where state is LOAD, load_en
//            is high and load_byte_vld is high. There is no back-pressure.
//
// Ports
//   clk, rst_n         clock (rising edge) and asynchronous active-low reset
//   fetch_req          fetch request this cycle
//   fetch_addr[31:0]   byte address of the instruction (PC)
//   fetch_instr[31:0]  registered instruction word
//   fetch_valid        fetch_instr and fetch_fault are valid this cycle
//   fetch_fault        request was misaligned or out of range
//   load_en            level: program-load session active
//   load_byte_vld      load_byte is valid this cycle
//   load_byte[7:0]     little-endian byte stream, starting at word 0
//   load_busy          high while in LOAD
//   load_done          one-cycle pulse (DONE state) at the end of a session
//   load_words[AW:0]   full words written in the last or current session
//   load_ovf           sticky: bytes arrived after DEPTH words were written
// ---------------------------------------------------------------------------
module imem_loadable #(
  parameter int          DEPTH    = 64,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013,
  // Derived word-index width; leave at its default.
  parameter int          AW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fetch_req,
  input  logic [31:0]   fetch_addr,
  output logic [31:0]   fetch_instr,
  output logic          fetch_valid,
  output logic          fetch_fault,
  input  logic          load_en,
  input  logic          load_byte_vld,
  input  logic [7:0]    load_byte,
  output logic          load_busy,
  output logic          load_done,
  output logic [AW:0]   load_words,
  output logic          load_ovf
);

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [AW:0] WORDS_FULL = (AW+1)'(DEPTH);

  // The array is not touched by reset. It starts out filled with NOPs.
  logic [31:0] mem [DEPTH] = '{default: NOP_WORD};

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [1:0]  byte_cnt;
  logic [23:0] asm_buf;      // first three bytes of the word being assembled

  logic        byte_take;
  logic        room;
  logic        word_wr;
  logic [31:0] word_data;
  logic        fetch_misalign;
  logic        fetch_oor;

  assign load_busy = (state == ST_LOAD);
  assign load_done = (state == ST_DONE);

  // load_words doubles as the write pointer for the current session.
  assign byte_take = (state == ST_LOAD) && load_en && load_byte_vld;
  assign room      = (load_words != WORDS_FULL);
  assign word_wr   = byte_take && room && (byte_cnt == 2'd3);
  // Bytes are shifted in from the top, so the first byte ends up in [7:0].
  assign word_data = {load_byte, asm_buf};

  assign fetch_misalign = |fetch_addr[1:0];
  assign fetch_oor      = |fetch_addr[31:AW+2];

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:  if (load_en)  state_nxt = ST_LOAD;
      ST_LOAD: if (!load_en) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_RUN;
      default: state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_RUN;
      byte_cnt   <= 2'd0;
      asm_buf    <= 24'd0;
      load_words <= '0;
      load_ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_RUN && load_en) begin
        load_words <= '0;
        byte_cnt   <= 2'd0;
        load_ovf   <= 1'b0;
      end else if (state == ST_LOAD) begin
        if (!load_en) begin
          // Leaving the session: any partial word is dropped.
          byte_cnt <= 2'd0;
        end else if (load_byte_vld) begin
          if (!room) begin
            load_ovf <= 1'b1;
          end else begin
            asm_buf  <= {load_byte, asm_buf[23:8]};
            byte_cnt <= byte_cnt + 2'd1;   // wraps to 0 on the fourth byte
            if (byte_cnt == 2'd3) load_words <= load_words + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (word_wr) mem[load_words[AW-1:0]] <= word_data;
  end

  // Fetch is blocked outside RUN. A write and a read of the same word
  // therefore never happen on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_valid <= 1'b0;
      fetch_fault <= 1'b0;
      fetch_instr <= NOP_WORD;
    end else begin
      fetch_valid <= fetch_req;
      if (fetch_req) begin
        if (state != ST_RUN) begin
          fetch_instr <= NOP_WORD;
          fetch_fault <= 1'b0;
        end else if (fetch_misalign || fetch_oor) begin
          fetch_instr <= NOP_WORD;
          fetch_fault <= 1'b1;
        end else begin
          fetch_instr <= mem[fetch_addr[AW+1:2]];
          fetch_fault <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_loadable.sv
module tb_imem_loadable;
  localparam int          DEPTH = 64;
  localparam int          AW    = $clog2(DEPTH);
  localparam logic [31:0] NOP   = 32'h0000_0013;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          fetch_req = 1'b0;
  logic [31:0]   fetch_addr = 32'd0;
  logic [31:0]   fetch_instr;
  logic          fetch_valid;
  logic          fetch_fault;
  logic          load_en = 1'b0;
  logic          load_byte_vld = 1'b0;
  logic [7:0]    load_byte = 8'd0;
  logic          load_busy;
  logic          load_done;
  logic [AW:0]   load_words;
  logic          load_ovf;

  imem_loadable #(.DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_instr(fetch_instr), .fetch_valid(fetch_valid), .fetch_fault(fetch_fault),
    .load_en(load_en), .load_byte_vld(load_byte_vld), .load_byte(load_byte),
    .load_busy(load_busy), .load_done(load_done),
    .load_words(load_words), .load_ovf(load_ovf)
  );

  // scoreboard: expected {fault, instr} per fetch request
  logic [32:0] exp_q[$];
  logic [32:0] mon_e;
  int n_checks = 0;
  int n_pass   = 0;

  // bench model of memory contents and load session
  logic [31:0] exp_mem [DEPTH];
  logic [31:0] m_word;
  int          m_cnt;
  int          m_ptr;
  logic        m_ovf;
  logic [7:0]  fixed_bytes [8];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [32:0] model_fetch(input logic [31:0] a);
    if (a[1:0] != 2'b00 || a >= 32'(DEPTH * 4)) return {1'b1, NOP};
    return {1'b0, exp_mem[a[AW+1:2]]};
  endfunction

  // driver tasks
  task automatic fetch(input logic [31:0] a, input logic [32:0] e);
    @(negedge clk);
    fetch_req  = 1'b1;
    fetch_addr = a;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    fetch_req = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic begin_load();
    @(negedge clk);
    load_en = 1'b1;
    @(negedge clk);
    check("busy_in_load", load_busy, 1);
    check("words_cleared", load_words, 0);
    check("ovf_cleared", load_ovf, 0);
    m_cnt = 0; m_ptr = 0; m_ovf = 1'b0; m_word = 32'd0;
  endtask

  // Sends n bytes starting at the current negedge; use_fixed selects fixed_bytes.
  task automatic send_bytes(input int n, input bit use_fixed);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = use_fixed ? fixed_bytes[i] : 8'($urandom_range(0, 255));
      load_byte_vld = 1'b1;
      load_byte     = b;
      if (m_ptr == DEPTH) m_ovf = 1'b1;
      else begin
        m_word[8*m_cnt +: 8] = b;
        m_cnt++;
        if (m_cnt == 4) begin
          exp_mem[m_ptr] = m_word;
          m_ptr++;
          m_cnt = 0;
        end
      end
      @(negedge clk);
    end
    load_byte_vld = 1'b0;
  endtask

  task automatic end_load();
    load_byte_vld = 1'b0;
    load_en = 1'b0;
    @(negedge clk);
    check("done_pulse", load_done, 1);
    check("busy_in_done", load_busy, 0);
    @(negedge clk);
    check("done_single", load_done, 0);
    check("load_words", load_words, 64'(m_ptr));
    check("load_ovf", load_ovf, m_ovf);
  endtask

  // monitor: pop one expectation per valid fetch cycle
  always @(negedge clk) begin
    if (rst_n && fetch_valid) begin
      if (exp_q.size() == 0) check("spurious_valid", fetch_valid, 0);
      else begin
        mon_e = exp_q.pop_front();
        check("fetch", {fetch_fault, fetch_instr}, mon_e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = NOP;
    fixed_bytes = '{8'h93, 8'h02, 8'h50, 8'h00, 8'h13, 8'h03, 8'ha0, 8'h00};

    // reset state
    repeat (2) @(negedge clk);
    check("rst_valid", fetch_valid, 0);
    check("rst_fault", fetch_fault, 0);
    check("rst_instr", fetch_instr, NOP);
    check("rst_busy", load_busy, 0);
    check("rst_done", load_done, 0);
    check("rst_words", load_words, 0);
    check("rst_ovf", load_ovf, 0);
    rst_n = 1'b1;

    // 1: back-to-back fetches from the NOP-filled array
    fetch(32'h0, {1'b0, NOP});
    fetch(32'h4, {1'b0, NOP});
    idle(3);

    // 2: load two words, then fetch them
    begin_load();
    send_bytes(8, 1'b1);
    end_load();
    fetch(32'h0, {1'b0, 32'h0050_0293});
    fetch(32'h4, {1'b0, 32'h00A0_0313});
    idle(3);

    // 3: fault boundaries
    fetch(32'h2, {1'b1, NOP});
    fetch(32'h100, {1'b1, NOP});
    fetch(32'hFC, {1'b0, NOP});
    fetch(32'hFFFF_FFF0, {1'b1, NOP});
    fetch(32'h1, {1'b1, NOP});
    idle(3);

    // 4: fill the whole array and overflow by three bytes
    begin_load();
    send_bytes(4 * DEPTH + 3, 1'b0);
    end_load();
    for (int i = 0; i < 6; i++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, DEPTH - 1)) << 2;
      fetch(a, model_fetch(a));
    end
    fetch(32'hFC, model_fetch(32'hFC));
    idle(3);

    // 5: six bytes -> one word; word 1 keeps its old value; fetch during LOAD gives NOP
    begin_load();
    fetch_req = 1'b1; fetch_addr = 32'h8;
    exp_q.push_back({1'b0, NOP});
    @(negedge clk);
    fetch_req = 1'b0;
    send_bytes(6, 1'b0);
    end_load();
    fetch(32'h0, model_fetch(32'h0));
    fetch(32'h4, model_fetch(32'h4));
    fetch(32'h8, model_fetch(32'h8));
    idle(3);

    // 6: reset after five bytes of a load
    begin_load();
    send_bytes(5, 1'b0);
    load_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("abort_busy", load_busy, 0);
    check("abort_done", load_done, 0);
    check("abort_words", load_words, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_no_done", load_done, 0);
    check("abort_run", load_busy, 0);
    fetch(32'h0, model_fetch(32'h0));
    fetch(32'h4, model_fetch(32'h4));
    fetch(32'h8, model_fetch(32'h8));
    idle(4);

    check("queue_drained", 64'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
